// File: rtl/instruction_load_controller_if.sv
// Loader handshake, instruction-memory bus and fetch-status signals of the
// instruction load controller. The controller connects to the slave modport.
interface instruction_load_controller_if;
   logic        startProgramLoading;
   logic [31:0] loadWord;
   logic        loadValid;
   logic        loadReady;
   logic [31:0] fromPC;
   logic        memWriteEnable;
   logic [31:0] memWriteAddress;
   logic [31:0] memWriteData;
   logic [31:0] memReadAddress;
   logic        programLoaded;
   logic        stallFetch;
   logic [15:0] wordsLoaded;
   logic        pcMisaligned;

   modport master (
      output startProgramLoading, loadWord, loadValid, fromPC,
      input  loadReady, memWriteEnable, memWriteAddress, memWriteData,
             memReadAddress, programLoaded, stallFetch, wordsLoaded, pcMisaligned
   );

   modport slave (
      input  startProgramLoading, loadWord, loadValid, fromPC,
      output loadReady, memWriteEnable, memWriteAddress, memWriteData,
             memReadAddress, programLoaded, stallFetch, wordsLoaded, pcMisaligned
   );
endinterface

// File: rtl/instruction_load_controller.sv
// Streams NUM_WORDS instruction words into instruction memory, then releases
// the fetch stage; a start request in RUN reloads the program from address 0.
module instruction_load_controller #(
   parameter int NUM_WORDS = 46
) (
   input logic                          clock,
   input logic                          reset,
   instruction_load_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

   state_t      state, state_nxt;
   logic [15:0] words_q;
   logic        we_q;
   logic [31:0] wa_q, wd_q;
   logic        accept, last_word, restart;

   assign accept    = bus.loadValid && (state == LOAD);
   assign last_word = (words_q == 16'(NUM_WORDS - 1));
   assign restart   = bus.startProgramLoading && ((state == IDLE) || (state == RUN));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.startProgramLoading) state_nxt = LOAD;
         LOAD:    if (accept && last_word)     state_nxt = RELEASE;
         RELEASE:                              state_nxt = RUN;
         RUN:     if (bus.startProgramLoading) state_nxt = LOAD;
         default:                              state_nxt = IDLE;
      endcase
   end

   // Write is registered one cycle after acceptance; reset drops any write
   // accepted on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         words_q <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         we_q <= accept;
         if (accept) begin
            wa_q    <= {14'd0, words_q, 2'b00};
            wd_q    <= bus.loadWord;
            words_q <= words_q + 16'd1;
         end else if (restart) begin
            words_q <= '0;
         end
      end
   end

   assign bus.loadReady       = (state == LOAD);
   assign bus.memWriteEnable  = we_q;
   assign bus.memWriteAddress = wa_q;
   assign bus.memWriteData    = wd_q;
   assign bus.wordsLoaded     = words_q;
   assign bus.programLoaded   = (state == RUN);
   assign bus.stallFetch      = (state != RUN);
   assign bus.memReadAddress  = (state == RUN) ? {bus.fromPC[31:2], 2'b00} : 32'd0;
   assign bus.pcMisaligned    = (state == RUN) && (bus.fromPC[1:0] != 2'b00);
endmodule
